// File: rtl/cache_set_controller.sv
// Initiator-side controller for one cache set: it does the lookup, drives the age-update pulses,
// selects a victim and runs writeback/fill transactions to next-level memory.
module cache_set_controller #(
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req_valid,
  output logic                              cpu_req_ready,
  input  logic                              cpu_req_write,
  input  logic [ADDRESS_WIDTH-1:0]          cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_req_wdata,
  output logic                              cpu_resp_valid,
  output logic                              cpu_resp_hit,
  output logic [DATA_WIDTH-1:0]             cpu_resp_rdata,
  output logic [ADDRESS_WIDTH-1:0]          way_address,
  output logic [NUM_WAYS-1:0]               way_allocate,
  output logic [NUM_WAYS-1:0]               way_wEn,
  output logic [DATA_WIDTH-1:0]             way_dataIn,
  output logic [NUM_WAYS-1:0]               way_accessed,
  output logic [COUNTER_WIDTH-1:0]          way_accessedWayAge,
  input  logic [NUM_WAYS*(ADDRESS_WIDTH-$clog2(BLOCK_SIZE))-1:0] way_tag,
  input  logic [NUM_WAYS-1:0]               way_valid,
  input  logic [NUM_WAYS-1:0]               way_dirty,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0]    way_dataOut,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_myAge,
  input  logic [NUM_WAYS-1:0]               way_expired,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]             mem_req_wdata,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_resp_rdata
);

  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int unsigned TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int unsigned IDX_W        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FILL_REQ  = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;
  localparam logic [2:0] S_INSTALL   = 3'd5;
  localparam logic [2:0] S_RESPOND   = 3'd6;

  localparam logic [NUM_WAYS-1:0] ONE_HOT_0 = {{(NUM_WAYS-1){1'b0}}, 1'b1};

  logic [2:0]               r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_write;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [IDX_W-1:0]         r_victim;
  logic [COUNTER_WIDTH-1:0] r_victim_age;
  logic [TAG_WIDTH-1:0]     r_victim_tag;
  logic [DATA_WIDTH-1:0]    r_victim_data;
  logic                     r_hit;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic [TAG_WIDTH-1:0]     w_req_tag;
  logic                     w_hit;
  logic [IDX_W-1:0]         w_hit_idx;
  logic                     w_inv_found, w_exp_found;
  logic [IDX_W-1:0]         w_inv_idx, w_exp_idx, w_old_idx, w_victim;
  logic [COUNTER_WIDTH-1:0] w_old_age;
  logic                     w_victim_dirty;

  assign w_req_tag = r_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];

  // Hit detection and victim priority: invalid, then expired, then oldest (ties to lowest index).
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_inv_found = 1'b0;
    w_inv_idx   = '0;
    w_exp_found = 1'b0;
    w_exp_idx   = '0;
    w_old_idx   = '0;
    w_old_age   = way_myAge[0 +: COUNTER_WIDTH];
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!w_hit && way_valid[i] && (way_tag[i*TAG_WIDTH +: TAG_WIDTH] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!w_inv_found && !way_valid[i]) begin
        w_inv_found = 1'b1;
        w_inv_idx   = IDX_W'(i);
      end
      if (!w_exp_found && way_expired[i]) begin
        w_exp_found = 1'b1;
        w_exp_idx   = IDX_W'(i);
      end
      if (way_myAge[i*COUNTER_WIDTH +: COUNTER_WIDTH] > w_old_age) begin
        w_old_age = way_myAge[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        w_old_idx = IDX_W'(i);
      end
    end
    if (w_inv_found)      w_victim = w_inv_idx;
    else if (w_exp_found) w_victim = w_exp_idx;
    else                  w_victim = w_old_idx;
    w_victim_dirty = way_valid[w_victim] && way_dirty[w_victim];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (cpu_req_valid) w_state_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)               w_state_next = S_RESPOND;
        else if (w_victim_dirty) w_state_next = S_WRITEBACK;
        else                     w_state_next = S_FILL_REQ;
      end
      S_WRITEBACK: if (mem_req_ready) w_state_next = S_FILL_REQ;
      S_FILL_REQ:  if (mem_req_ready) w_state_next = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_resp_valid) w_state_next = S_INSTALL;
      S_INSTALL:   w_state_next = S_RESPOND;
      S_RESPOND:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_victim      <= '0;
      r_victim_age  <= '0;
      r_victim_tag  <= '0;
      r_victim_data <= '0;
      r_hit         <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            r_addr  <= cpu_req_addr;
            r_write <= cpu_req_write;
            r_wdata <= cpu_req_wdata;
            r_hit   <= 1'b0;
            r_rdata <= '0;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_hit   <= 1'b1;
            r_rdata <= way_dataOut[int'(w_hit_idx)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            r_victim      <= w_victim;
            r_victim_age  <= way_myAge[int'(w_victim)*COUNTER_WIDTH +: COUNTER_WIDTH];
            r_victim_tag  <= way_tag[int'(w_victim)*TAG_WIDTH +: TAG_WIDTH];
            r_victim_data <= way_dataOut[int'(w_victim)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_FILL_WAIT: if (mem_resp_valid) r_rdata <= mem_resp_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_req_ready      = (r_state == S_IDLE);
    cpu_resp_valid     = 1'b0;
    cpu_resp_hit       = 1'b0;
    cpu_resp_rdata     = '0;
    way_address        = (r_state == S_IDLE) ? '0 : r_addr;
    way_allocate       = '0;
    way_wEn            = '0;
    way_dataIn         = '0;
    way_accessed       = '0;
    way_accessedWayAge = '0;
    mem_req_valid      = 1'b0;
    mem_req_write      = 1'b0;
    mem_req_addr       = '0;
    mem_req_wdata      = '0;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          way_accessed       = ONE_HOT_0 << w_hit_idx;
          way_accessedWayAge = way_myAge[int'(w_hit_idx)*COUNTER_WIDTH +: COUNTER_WIDTH];
          if (r_write) begin
            way_wEn    = ONE_HOT_0 << w_hit_idx;
            way_dataIn = r_wdata;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {r_victim_tag, {OFFSET_WIDTH{1'b0}}};
        mem_req_wdata = r_victim_data;
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_req_tag, {OFFSET_WIDTH{1'b0}}};
      end
      S_INSTALL: begin
        way_allocate       = ONE_HOT_0 << r_victim;
        way_wEn            = ONE_HOT_0 << r_victim;
        way_accessed       = ONE_HOT_0 << r_victim;
        way_dataIn         = r_write ? r_wdata : r_rdata;
        way_accessedWayAge = r_victim_age;
      end
      S_RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = r_hit;
        cpu_resp_rdata = r_write ? '0 : r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_set_controller.sv
// Directed bench for cache_set_controller: way state is driven directly and every expected value
// below is hand-computed from the intended behaviour.
module tb_cache_set_controller;

  localparam int NW = 4;
  localparam int TW = 27;
  localparam int CW = 8;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [31:0]       cpu_req_addr, cpu_req_wdata;
  logic              cpu_resp_valid, cpu_resp_hit;
  logic [31:0]       cpu_resp_rdata, way_address, way_dataIn;
  logic [NW-1:0]     way_allocate, way_wEn, way_accessed;
  logic [CW-1:0]     way_accessedWayAge;
  logic [NW*TW-1:0]  way_tag;
  logic [NW-1:0]     way_valid, way_dirty, way_expired;
  logic [NW*DW-1:0]  way_dataOut;
  logic [NW*CW-1:0]  way_myAge;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]       mem_req_addr, mem_req_wdata;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_set_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
    .cpu_resp_rdata(cpu_resp_rdata),
    .way_address(way_address), .way_allocate(way_allocate), .way_wEn(way_wEn),
    .way_dataIn(way_dataIn), .way_accessed(way_accessed),
    .way_accessedWayAge(way_accessedWayAge),
    .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_dataOut(way_dataOut), .way_myAge(way_myAge), .way_expired(way_expired),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_way(input int i, input logic [26:0] tag, input logic v, input logic d,
                         input logic e, input logic [7:0] age, input logic [31:0] data);
    way_tag[i*TW +: TW]     = tag;
    way_valid[i]            = v;
    way_dirty[i]            = d;
    way_expired[i]          = e;
    way_myAge[i*CW +: CW]   = age;
    way_dataOut[i*DW +: DW] = data;
  endtask

  // Presents one request in IDLE and returns just after the accept edge (state LOOKUP).
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    #1;
    chk("ready_before_accept", cpu_req_ready, 1);
    tick();
    cpu_req_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {way_allocate, way_wEn, way_accessed}, 0);
    chk({tag, "_memv"}, mem_req_valid, 0);
    chk({tag, "_respv"}, cpu_resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    way_tag = '0; way_valid = '0; way_dirty = '0; way_expired = '0;
    way_dataOut = '0; way_myAge = '0;
    tick(); tick();
    chk_quiet("reset");
    chk("reset_addr", way_address, 0);
    rst = 1'b0;
    tick();
    chk("reset_ready", cpu_req_ready, 1);
    chk_quiet("post_reset");

    // Read hit on way2
    set_way(0, 27'h10, 1, 0, 0, 8'd3, 32'h0);
    set_way(1, 27'h11, 1, 0, 0, 8'd3, 32'h0);
    set_way(2, 27'h1234, 1, 0, 0, 8'd7, 32'hDEADBEEF);
    set_way(3, 27'h13, 1, 0, 0, 8'd3, 32'h0);
    send(0, 32'h24680, 0);
    chk("hit_lookup_ready", cpu_req_ready, 0);
    chk("hit_lookup_addr", way_address, 32'h24680);
    chk("hit_accessed", way_accessed, 4'b0100);
    chk("hit_age", way_accessedWayAge, 7);
    chk("hit_lookup_wen", way_wEn, 0);
    chk("hit_lookup_respv", cpu_resp_valid, 0);
    tick();
    chk("hit_respv", cpu_resp_valid, 1);
    chk("hit_flag", cpu_resp_hit, 1);
    chk("hit_rdata", cpu_resp_rdata, 32'hDEADBEEF);
    chk("hit_accessed_off", way_accessed, 0);
    tick();
    chk("hit_idle_ready", cpu_req_ready, 1);
    chk_quiet("hit_idle");

    // Read miss, ways 2,3 invalid (way2 dirty bit set but invalid: no writeback)
    set_way(0, 27'h20, 1, 0, 0, 8'd1, 32'h0);
    set_way(1, 27'h21, 1, 0, 0, 8'd2, 32'h0);
    set_way(2, 27'h22, 0, 1, 0, 8'h11, 32'h0);
    set_way(3, 27'h23, 0, 0, 0, 8'd4, 32'h0);
    send(0, 32'h6004, 0);
    chk_quiet("miss_lookup");
    tick();
    chk("miss_fill_v", mem_req_valid, 1);
    chk("miss_fill_wr", mem_req_write, 0);
    chk("miss_fill_addr", mem_req_addr, 32'h6000);
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h0BAD0BAD;
    tick();
    mem_req_ready = 0; mem_resp_valid = 0;
    chk("miss_wait_memv", mem_req_valid, 0);
    tick();
    tick();
    chk("miss_wait_still", {way_allocate, cpu_resp_valid}, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'hCAFEF00D;
    tick();
    mem_resp_valid = 0;
    chk("miss_alloc", way_allocate, 4'b0100);
    chk("miss_wen", way_wEn, 4'b0100);
    chk("miss_accessed", way_accessed, 4'b0100);
    chk("miss_datain", way_dataIn, 32'hCAFEF00D);
    chk("miss_age", way_accessedWayAge, 8'h11);
    tick();
    chk("miss_resp", {cpu_resp_valid, cpu_resp_hit, cpu_resp_rdata}, {2'b10, 32'hCAFEF00D});
    chk("miss_resp_strobes", {way_allocate, way_wEn, way_accessed}, 0);
    tick();
    chk("miss_idle_ready", cpu_req_ready, 1);

    // Dirty eviction: ages {5,9,9,2}, way1 dirty
    set_way(0, 27'h40, 1, 0, 0, 8'd5, 32'h0);
    set_way(1, 27'h41, 1, 1, 0, 8'd9, 32'h11112222);
    set_way(2, 27'h42, 1, 0, 0, 8'd9, 32'h0);
    set_way(3, 27'h43, 1, 0, 0, 8'd2, 32'h0);
    send(0, 32'hA000, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_req_ready = 1;
      #1;
      chk("wb_fields", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata},
          {2'b11, 32'h820, 32'h11112222});
      tick();
    end
    chk("wb_fill_req", {mem_req_valid, mem_req_write, mem_req_addr}, {2'b10, 32'hA000});
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h77778888;
    tick();
    mem_resp_valid = 0;
    chk("wb_alloc", way_allocate, 4'b0010);
    chk("wb_age", way_accessedWayAge, 9);
    chk("wb_datain", way_dataIn, 32'h77778888);
    tick();
    chk("wb_resp", {cpu_resp_valid, cpu_resp_hit, cpu_resp_rdata}, {2'b10, 32'h77778888});
    tick();

    // Expired way beats the oldest way
    set_way(0, 27'h60, 1, 0, 0, 8'd200, 32'h0);
    set_way(1, 27'h61, 1, 0, 0, 8'd50, 32'h0);
    set_way(2, 27'h62, 1, 0, 0, 8'd50, 32'h0);
    set_way(3, 27'h63, 1, 0, 1, 8'd1, 32'h0);
    send(0, 32'hE000, 0);
    tick();
    chk("exp_fill_req", {mem_req_valid, mem_req_write, mem_req_addr}, {2'b10, 32'hE000});
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h00C0FFEE;
    tick();
    mem_resp_valid = 0;
    chk("exp_alloc", way_allocate, 4'b1000);
    chk("exp_age", way_accessedWayAge, 1);
    tick(); tick();

    // Write hit on way0 with cpu_req_valid held high throughout
    set_way(0, 27'h80, 1, 0, 0, 8'd4, 32'h55);
    cpu_req_valid = 1; cpu_req_write = 1; cpu_req_addr = 32'h1000; cpu_req_wdata = 32'h55;
    tick();
    chk("wr_wen", way_wEn, 4'b0001);
    chk("wr_datain", way_dataIn, 32'h55);
    chk("wr_accessed", way_accessed, 4'b0001);
    chk("wr_age", way_accessedWayAge, 4);
    chk("wr_lookup_ready", cpu_req_ready, 0);
    tick();
    chk("wr_resp", {cpu_resp_valid, cpu_resp_hit, cpu_resp_rdata}, {2'b11, 32'h0});
    chk("wr_resp_ready", cpu_req_ready, 0);
    tick();
    chk("wr_idle_ready", cpu_req_ready, 1);
    chk_quiet("wr_idle");
    cpu_req_write = 0;
    tick();
    cpu_req_valid = 0;
    chk("b2b_lookup", {cpu_req_ready, way_accessed, way_wEn}, {1'b0, 4'b0001, 4'b0000});
    tick();
    chk("b2b_resp", {cpu_resp_valid, cpu_resp_hit, cpu_resp_rdata}, {2'b11, 32'h55});
    tick();
    chk("b2b_idle", {cpu_req_ready, cpu_resp_valid}, 2'b10);

    // Reset while in writeback
    set_way(0, 27'h40, 1, 0, 0, 8'd5, 32'h0);
    set_way(1, 27'h41, 1, 1, 0, 8'd9, 32'h11112222);
    set_way(2, 27'h42, 1, 0, 0, 8'd9, 32'h0);
    set_way(3, 27'h43, 1, 0, 0, 8'd2, 32'h0);
    send(0, 32'hA000, 0);
    tick();
    chk("rst_wb_active", {mem_req_valid, mem_req_write}, 2'b11);
    rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h12345678;
    tick();
    chk_quiet("rst_mid");
    chk("rst_mid_addr", way_address, 0);
    rst = 0;
    tick();
    chk("rst_rel_ready", cpu_req_ready, 1);
    chk_quiet("rst_rel");
    tick();
    chk("rst_stray_resp", {cpu_req_ready, way_allocate, cpu_resp_valid, mem_req_valid},
        {1'b1, 4'b0, 2'b0});
    mem_resp_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
